// File: rtl/alu_dec_core.sv
// alu_dec_core: registered 8-bit ALU with NMOS-style BCD adjust, carry chain and page-cross output
module alu_dec_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       b_load,
  input  logic [1:0] c_sel,
  input  logic       p_c,
  input  logic       p_d,
  input  logic       dec_en,
  input  logic [3:0] alu_op,
  output logic [7:0] alu_out,
  output logic [7:0] adj_out,
  output logic       carry_out,
  output logic       half_carry,
  output logic       flag_z,
  output logic       flag_v,
  output logic       flag_n,
  output logic       carry_last,
  output logic       a_sign,
  output logic       page_cross
);
  logic [7:0] a_reg, b_reg;
  logic [4:0] lo, hi;
  logic       c, adder, dec_add, dec_sub, hc_add, cy_add;
  logic [3:0] adj_lo, adj_hi;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry_last <= 1'b0;
    end else begin
      a_reg      <= a_in;
      carry_last <= carry_out;
      if (b_load) b_reg <= b_in;
    end
  always_comb begin
    c       = c_sel == 2'd0 ? 1'b0 : c_sel == 2'd1 ? 1'b1 : c_sel == 2'd2 ? p_c : carry_last;
    adder   = alu_op[3:1] == 3'd0;
    dec_add = p_d & dec_en & (alu_op == 4'd0);
    dec_sub = p_d & dec_en & (alu_op == 4'd1);
    lo      = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'd0, c};
    hc_add  = dec_add ? (lo > 5'd9) : lo[4];
    hi      = {1'b0, a_reg[7:4]} + {1'b0, b_reg[7:4]} + {4'd0, hc_add};
    cy_add  = dec_add ? (hi > 5'd9) : hi[4];
    alu_out    = 8'h00;
    carry_out  = 1'b0;
    half_carry = adder & hc_add;
    case (alu_op)
      4'd0, 4'd1: begin
        alu_out   = {hi[3:0], lo[3:0]};
        carry_out = cy_add;
      end
      4'd2: alu_out = a_reg | b_reg;
      4'd3: alu_out = a_reg & b_reg;
      4'd4: alu_out = a_reg ^ b_reg;
      4'd5: begin
        alu_out   = {c, a_reg[7:1]};
        carry_out = a_reg[0];
      end
      4'd6: begin
        alu_out   = {a_reg[6:0], c};
        carry_out = a_reg[7];
      end
      4'd7: alu_out = a_reg;
      4'd8: alu_out = b_reg;
      default: alu_out = 8'h00;
    endcase
    // Nibbles adjust independently; the inter-nibble carry already went through the adder.
    adj_lo  = alu_out[3:0] + (dec_add & half_carry ? 4'h6 : dec_sub & ~half_carry ? 4'hA : 4'h0);
    adj_hi  = alu_out[7:4] + (dec_add & carry_out ? 4'h6 : dec_sub & ~carry_out ? 4'hA : 4'h0);
    adj_out = {adj_hi, adj_lo};
    flag_z  = alu_out == 8'h00;
    flag_n  = alu_out[7];
    flag_v  = adder & ~(a_reg[7] ^ b_reg[7]) & (a_reg[7] ^ alu_out[7]);
  end
  assign a_sign     = a_reg[7];
  assign page_cross = carry_out ^ a_sign;
endmodule

// File: tb/tb_alu_dec_core.sv
// tb_alu_dec_core: directed vectors with hand-computed results for alu_dec_core
module tb_alu_dec_core;
  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       b_load = 1'b0, p_c = 1'b0, p_d = 1'b0, dec_en = 1'b0;
  logic [1:0] c_sel = '0;
  logic [3:0] alu_op = '0;
  logic [7:0] alu_out, adj_out;
  logic       carry_out, half_carry, flag_z, flag_v, flag_n, carry_last, a_sign, page_cross;
  int         n_cmp = 0, n_bad = 0;
  alu_dec_core dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .b_load(b_load), .c_sel(c_sel),
    .p_c(p_c), .p_d(p_d), .dec_en(dec_en), .alu_op(alu_op), .alu_out(alu_out), .adj_out(adj_out),
    .carry_out(carry_out), .half_carry(half_carry), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .carry_last(carry_last), .a_sign(a_sign), .page_cross(page_cross)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic bl, input logic [1:0] cs, input logic pd, input logic de,
                       input logic pc);
    alu_op = op; a_in = a; b_in = b; b_load = bl; c_sel = cs; p_d = pd; dec_en = de; p_c = pc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_alu", alu_out, 8'h00);
    chk("rst_adj", adj_out, 8'h00);
    chk("rst_z", flag_z, 1);
    chk("rst_flags", {carry_out, half_carry, flag_v, flag_n, carry_last, a_sign, page_cross}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply(0, 8'h50, 8'h50, 1, 0, 0, 0, 0);
    chk("bin_out", alu_out, 8'hA0);
    chk("bin_vnc", {flag_v, flag_n, carry_out}, 3'b110);
    apply(0, 8'h99, 8'h01, 1, 0, 1, 1, 0);
    chk("bcd_add_out", alu_out, 8'hAA);
    chk("bcd_add_adj", adj_out, 8'h00);
    chk("bcd_add_czh", {carry_out, flag_z, half_carry}, 3'b101);
    apply(1, 8'h10, 8'hFE, 1, 1, 1, 1, 0);
    chk("bcd_sub_out", alu_out, 8'h0F);
    chk("bcd_sub_adj", adj_out, 8'h09);
    chk("bcd_sub_c", carry_out, 1);
    apply(1, 8'h00, 8'hFE, 1, 1, 1, 1, 0);
    chk("bcd_borrow_adj", adj_out, 8'h99);
    chk("bcd_borrow_c", carry_out, 0);
    apply(0, 8'h09, 8'h01, 1, 0, 1, 0, 0);
    chk("no_dec_adj", adj_out, 8'h0A);
    apply(0, 8'h01, 8'h01, 1, 2, 0, 0, 1);
    chk("csel_pc", alu_out, 8'h03);
    apply(5, 8'h81, 8'h00, 1, 1, 0, 0, 0);
    chk("sr_out", alu_out, 8'hC0);
    chk("sr_c", carry_out, 1);
    apply(6, 8'h80, 8'h00, 1, 0, 0, 0, 0);
    chk("sl_out", alu_out, 8'h00);
    chk("sl_cz", {carry_out, flag_z}, 2'b11);
    apply(2, 8'hF0, 8'h0C, 1, 1, 0, 0, 0);
    chk("or", alu_out, 8'hFC);
    chk("or_hc", {carry_out, half_carry, flag_v}, 0);
    apply(3, 8'hF0, 8'h3C, 1, 0, 0, 0, 0);
    chk("and", alu_out, 8'h30);
    apply(4, 8'hFF, 8'h0F, 1, 0, 0, 0, 0);
    chk("eor", alu_out, 8'hF0);
    apply(7, 8'h7E, 8'h00, 1, 0, 0, 0, 0);
    chk("pass_a", alu_out, 8'h7E);
    alu_op = 8;
    #1;
    chk("pass_b_z", {alu_out, flag_z}, 9'h001);
    alu_op = 9;
    c_sel  = 1;
    #1;
    chk("op9", {alu_out, carry_out}, 9'h000);
    apply(0, 8'h10, 8'hF5, 1, 0, 0, 0, 0);
    chk("pgx_carry", {carry_out, a_sign, page_cross}, 3'b101);
    apply(0, 8'hFF, 8'h01, 1, 0, 0, 0, 0);
    chk("chain1_out", alu_out, 8'h00);
    chk("chain1_c_pgx", {carry_out, a_sign, page_cross}, 3'b110);
    apply(0, 8'h12, 8'h99, 0, 3, 0, 0, 0);
    chk("chain2_cl", carry_last, 1);
    chk("chain2_out", alu_out, 8'h14);
    apply(0, 8'hFF, 8'h01, 1, 1, 0, 0, 0);
    apply(0, 8'hFF, 8'h01, 1, 1, 0, 0, 0);
    chk("pre_rst_cl", carry_last, 1);
    c_sel = 0;
    reset = 1'b0;
    #1;
    chk("mid_rst_cl", carry_last, 0);
    chk("mid_rst_out", alu_out, 8'h00);
    chk("mid_rst_z", flag_z, 1);
    a_in = 8'h05; b_in = 8'h03;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", alu_out, 8'h08);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
